// File: rtl/ddr3_ui_traffic_gen.sv
// Write-then-readback memory exerciser for a DDR3 UI port: one burst per accepted command/data pair, no bubbles between bursts.
// All outputs registered; app_en and app_wdf_wren are held independently until app_rdy / app_wdf_rdy accept them.
module ddr3_ui_traffic_gen #(
    parameter int ADDR_WIDTH     = 29,
    parameter int APP_DATA_WIDTH = 512,
    parameter int NUM_BURSTS     = 256,
    parameter int BASE_ADDR      = 0,
    parameter int ADDR_STEP      = 8,
    parameter int LOOP           = 1
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        init_calib_complete,
    output logic [ADDR_WIDTH-1:0]       app_addr,
    output logic [2:0]                  app_cmd,
    output logic                        app_en,
    input  logic                        app_rdy,
    output logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
    output logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
    output logic                        app_wdf_wren,
    output logic                        app_wdf_end,
    input  logic                        app_wdf_rdy,
    input  logic [APP_DATA_WIDTH-1:0]   app_rd_data,
    input  logic                        app_rd_data_valid,
    input  logic                        app_rd_data_end,
    output logic                        tg_compare_error,
    output logic [15:0]                 err_count,
    output logic [31:0]                 pass_count
);
    localparam int IW = 17;
    localparam int NW = APP_DATA_WIDTH / 32;
    localparam logic [IW-1:0] NB   = IW'(NUM_BURSTS);
    localparam logic [IW-1:0] LAST = IW'(NUM_BURSTS - 1);
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   wr_idx, rd_cmd_idx, rd_chk_idx;
    logic            cmd_done, dat_done;
    logic            cmd_acc, dat_acc, cmd_ok, dat_ok, rd_miss;
    logic [IW-1:0]   wr_nxt, rd_cmd_nxt, rd_chk_nxt;
    logic [31:0]     pass_nxt;
    logic            unused_rd_end;

    function automatic logic [ADDR_WIDTH-1:0] burst_addr(input logic [IW-1:0] k);
        return ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(k) * ADDR_WIDTH'(ADDR_STEP);
    endfunction

    function automatic logic [APP_DATA_WIDTH-1:0] burst_data(input logic [7:0] p, input logic [IW-1:0] k);
        logic [APP_DATA_WIDTH-1:0] d;
        d = '0;
        for (int i = 0; i < NW; i++) d[i*32 +: 32] = {p, k[15:0], 8'(i)};
        return d;
    endfunction

    assign cmd_acc    = app_en & app_rdy;
    assign dat_acc    = app_wdf_wren & app_wdf_rdy;
    assign cmd_ok     = cmd_done | cmd_acc;
    assign dat_ok     = dat_done | dat_acc;
    assign wr_nxt     = wr_idx + IW'(1);
    assign rd_cmd_nxt = rd_cmd_idx + IW'(cmd_acc);
    assign rd_chk_nxt = rd_chk_idx + IW'(1);
    assign pass_nxt   = pass_count + 32'd1;
    assign rd_miss    = app_rd_data != burst_data(pass_count[7:0], rd_chk_idx);

    assign app_wdf_end   = app_wdf_wren;
    assign app_wdf_mask  = '0;
    assign unused_rd_end = app_rd_data_end;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state            <= IDLE;
            wr_idx           <= '0;
            rd_cmd_idx       <= '0;
            rd_chk_idx       <= '0;
            cmd_done         <= 1'b0;
            dat_done         <= 1'b0;
            app_en           <= 1'b0;
            app_wdf_wren     <= 1'b0;
            app_cmd          <= CMD_WR;
            app_addr         <= '0;
            app_wdf_data     <= '0;
            tg_compare_error <= 1'b0;
            err_count        <= '0;
            pass_count       <= '0;
        end else if ((state == WRITE || state == READ) && !init_calib_complete) begin
            // Calibration lost: abandon the pass, keep the result counters.
            state        <= IDLE;
            app_en       <= 1'b0;
            app_wdf_wren <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (init_calib_complete) begin
                        state        <= WRITE;
                        wr_idx       <= '0;
                        rd_cmd_idx   <= '0;
                        rd_chk_idx   <= '0;
                        cmd_done     <= 1'b0;
                        dat_done     <= 1'b0;
                        app_cmd      <= CMD_WR;
                        app_addr     <= burst_addr('0);
                        app_wdf_data <= burst_data(pass_count[7:0], '0);
                        app_en       <= 1'b1;
                        app_wdf_wren <= 1'b1;
                    end
                end
                WRITE: begin
                    if (cmd_ok && dat_ok) begin
                        cmd_done <= 1'b0;
                        dat_done <= 1'b0;
                        if (wr_idx == LAST) begin
                            // One quiet cycle separates the last write from the first read.
                            state        <= READ;
                            app_cmd      <= CMD_RD;
                            app_en       <= 1'b0;
                            app_wdf_wren <= 1'b0;
                        end else begin
                            wr_idx       <= wr_nxt;
                            app_addr     <= burst_addr(wr_nxt);
                            app_wdf_data <= burst_data(pass_count[7:0], wr_nxt);
                            app_en       <= 1'b1;
                            app_wdf_wren <= 1'b1;
                        end
                    end else begin
                        cmd_done     <= cmd_ok;
                        dat_done     <= dat_ok;
                        app_en       <= !cmd_ok;
                        app_wdf_wren <= !dat_ok;
                    end
                end
                READ: begin
                    rd_cmd_idx <= rd_cmd_nxt;
                    app_en     <= (rd_cmd_nxt != NB);
                    app_addr   <= burst_addr(rd_cmd_nxt);
                    if (app_rd_data_valid) begin
                        rd_chk_idx <= rd_chk_nxt;
                        if (rd_miss) begin
                            tg_compare_error <= 1'b1;
                            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                        end
                        if (rd_chk_nxt == NB) begin
                            pass_count <= pass_nxt;
                            if (LOOP != 0) begin
                                state        <= WRITE;
                                wr_idx       <= '0;
                                rd_cmd_idx   <= '0;
                                rd_chk_idx   <= '0;
                                cmd_done     <= 1'b0;
                                dat_done     <= 1'b0;
                                app_cmd      <= CMD_WR;
                                app_addr     <= burst_addr('0);
                                app_wdf_data <= burst_data(pass_nxt[7:0], '0);
                                app_en       <= 1'b1;
                                app_wdf_wren <= 1'b1;
                            end else begin
                                state  <= DONE;
                                app_en <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    app_en       <= 1'b0;
                    app_wdf_wren <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ddr3_ui_traffic_gen.sv
// Two generators against queue/array memory models: a single-pass one (directed scenarios) and a looping one with address wrap.
module tb_ddr3_ui_traffic_gen;
    localparam int AW = 29, DW = 64, NB = 4;
    localparam int LAW = 8, LDW = 96, LNB = 3;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1, calib = 1'b0;
    logic l_rst = 1'b1, l_calib = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic [AW-1:0]   app_addr;
    logic [2:0]      app_cmd;
    logic            app_en, app_wdf_wren, app_wdf_end, tg_compare_error;
    logic            app_rdy = 1'b0, app_wdf_rdy = 1'b0;
    logic [DW-1:0]   app_wdf_data;
    logic [DW/8-1:0] app_wdf_mask;
    logic [DW-1:0]   app_rd_data = '0;
    logic            app_rd_data_valid = 1'b0;
    logic [15:0]     err_count;
    logic [31:0]     pass_count;

    logic [LAW-1:0]   l_app_addr;
    logic [2:0]       l_app_cmd;
    logic             l_app_en, l_app_wdf_wren, l_app_wdf_end, l_tg;
    logic             l_app_rdy = 1'b0, l_app_wdf_rdy = 1'b0;
    logic [LDW-1:0]   l_app_wdf_data;
    logic [LDW/8-1:0] l_app_wdf_mask;
    logic [LDW-1:0]   l_app_rd_data = '0;
    logic             l_app_rd_data_valid = 1'b0;
    logic [15:0]      l_err_count;
    logic [31:0]      l_pass_count;

    ddr3_ui_traffic_gen #(.ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .NUM_BURSTS(NB),
                          .BASE_ADDR(0), .ADDR_STEP(8), .LOOP(0)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_calib_complete(calib),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_valid),
        .tg_compare_error(tg_compare_error), .err_count(err_count), .pass_count(pass_count));

    ddr3_ui_traffic_gen #(.ADDR_WIDTH(LAW), .APP_DATA_WIDTH(LDW), .NUM_BURSTS(LNB),
                          .BASE_ADDR(240), .ADDR_STEP(32), .LOOP(1)) u_loop (
        .sys_clk(sys_clk), .sys_rst(l_rst), .init_calib_complete(l_calib),
        .app_addr(l_app_addr), .app_cmd(l_app_cmd), .app_en(l_app_en), .app_rdy(l_app_rdy),
        .app_wdf_data(l_app_wdf_data), .app_wdf_mask(l_app_wdf_mask), .app_wdf_wren(l_app_wdf_wren),
        .app_wdf_end(l_app_wdf_end), .app_wdf_rdy(l_app_wdf_rdy), .app_rd_data(l_app_rd_data),
        .app_rd_data_valid(l_app_rd_data_valid), .app_rd_data_end(l_app_rd_data_valid),
        .tg_compare_error(l_tg), .err_count(l_err_count), .pass_count(l_pass_count));

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected burst contents straight from the pattern rule: word i = pass byte, burst index, word index.
    function automatic logic [127:0] pat(input int words, input int p, input int k);
        logic [127:0] d;
        d = '0;
        for (int i = 0; i < words; i++) d[i*32 +: 32] = 32'(((p % 256) << 24) + ((k % 65536) << 8) + i);
        return d;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    bit rand_rdy = 1'b0, rdy_val = 1'b1, rd_slow = 1'b0, junk_req = 1'b0;
    int corrupt_k = -1;

    always @(negedge sys_clk) begin
        app_rdy       = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_val;
        app_wdf_rdy   = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        l_app_rdy     = ($urandom_range(0, 2) != 0);
        l_app_wdf_rdy = ($urandom_range(0, 2) != 0);
    end

    // Memory model for the single-pass generator.
    int wr_cmds, wr_beats, rd_cmds, rd_beats, first_addr;
    int q_addr[$], rd_q[$];
    logic [DW-1:0] q_dat[$];
    logic [DW-1:0] mem_a [int];
    bit rd_seen, prev_busy, err_s1, err_s2;

    always @(posedge sys_clk) begin : model_a
        logic [DW-1:0] d;
        bit v;
        int ad;
        d = '0;
        v = 1'b0;
        if (!sys_rst) begin
            if (err_s2) begin
                check("err_flag_after_beat", tg_compare_error, 1);
                check("err_count_after_beat", err_count, 1);
            end
            if (err_s1) check("err_flag_before_beat", tg_compare_error, 0);
            err_s2 = err_s1;
            err_s1 = 1'b0;
        end
        if (sys_rst || !calib) begin
            wr_cmds = 0; wr_beats = 0; rd_cmds = 0; rd_beats = 0; first_addr = -1;
            q_addr.delete(); q_dat.delete(); rd_q.delete();
            rd_seen = 1'b0; prev_busy = 1'b0; err_s1 = 1'b0; err_s2 = 1'b0;
            app_rd_data_valid <= 1'b0;
        end else begin
            check("wdf_end", app_wdf_end, app_wdf_wren);
            check("wdf_mask", app_wdf_mask, 0);
            if (app_en && app_cmd == 3'b001 && !rd_seen) begin
                check("rd_gap_after_writes", prev_busy, 0);
                rd_seen = 1'b1;
            end
            if (app_en && app_rdy && app_cmd == 3'b000) begin
                check("wr_addr", app_addr, 128'(wr_cmds * 8));
                if (wr_cmds == 0) first_addr = int'(app_addr);
                q_addr.push_back(int'(app_addr));
                wr_cmds++;
            end
            if (app_en && app_rdy && app_cmd == 3'b001) begin
                check("rd_addr", app_addr, 128'(rd_cmds * 8));
                check("rd_after_all_writes", wr_beats, NB);
                rd_q.push_back(int'(app_addr));
                rd_cmds++;
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                check("wr_data", app_wdf_data, pat(DW / 32, 0, wr_beats));
                q_dat.push_back(app_wdf_data);
                wr_beats++;
            end
            while (q_addr.size() > 0 && q_dat.size() > 0) mem_a[q_addr.pop_front()] = q_dat.pop_front();
            prev_busy = app_en | app_wdf_wren;
            if (junk_req) begin
                v = 1'b1;
                d = {$urandom, $urandom};
            end else if (rd_q.size() > 0 && (!rd_slow || $urandom_range(0, 1) == 1)) begin
                ad = rd_q.pop_front();
                d = mem_a.exists(ad) ? mem_a[ad] : '0;
                if (rd_beats == corrupt_k) begin
                    d[0] = ~d[0];
                    err_s1 = 1'b1;
                end
                v = 1'b1;
                rd_beats++;
            end
            app_rd_data       <= d;
            app_rd_data_valid <= v;
        end
    end

    // Memory model for the looping generator; pass number follows from total beats written.
    int l_wr_cmds, l_wr_beats, l_rd_cmds;
    int lq_addr[$], lrd_q[$];
    logic [LDW-1:0] lq_dat[$];
    logic [LDW-1:0] mem_l [int];
    int l_byte[4] = '{-1, -1, -1, -1};

    always @(posedge sys_clk) begin : model_l
        int ad;
        if (l_rst || !l_calib) begin
            l_wr_cmds = 0; l_wr_beats = 0; l_rd_cmds = 0;
            lq_addr.delete(); lq_dat.delete(); lrd_q.delete();
            l_app_rd_data_valid <= 1'b0;
        end else begin
            check("l_wdf_end", l_app_wdf_end, l_app_wdf_wren);
            check("l_wdf_mask", l_app_wdf_mask, 0);
            if (l_app_en && l_app_rdy) begin
                if (l_app_cmd == 3'b000) begin
                    check("l_wr_addr_wrap", l_app_addr, 128'((240 + (l_wr_cmds % LNB) * 32) % 256));
                    lq_addr.push_back(int'(l_app_addr));
                    l_wr_cmds++;
                end else begin
                    check("l_rd_addr_wrap", l_app_addr, 128'((240 + (l_rd_cmds % LNB) * 32) % 256));
                    lrd_q.push_back(int'(l_app_addr));
                    l_rd_cmds++;
                end
            end
            if (l_app_wdf_wren && l_app_wdf_rdy) begin
                check("l_wr_data", l_app_wdf_data, pat(LDW / 32, l_wr_beats / LNB, l_wr_beats % LNB));
                if (l_wr_beats % LNB == 0 && l_wr_beats / LNB < 4) l_byte[l_wr_beats / LNB] = int'(l_app_wdf_data[31:24]);
                lq_dat.push_back(l_app_wdf_data);
                l_wr_beats++;
            end
            while (lq_addr.size() > 0 && lq_dat.size() > 0) mem_l[lq_addr.pop_front()] = lq_dat.pop_front();
            if (lrd_q.size() > 0) begin
                ad = lrd_q.pop_front();
                l_app_rd_data       <= mem_l.exists(ad) ? mem_l[ad] : '0;
                l_app_rd_data_valid <= 1'b1;
            end else begin
                l_app_rd_data_valid <= 1'b0;
            end
        end
    end

    task automatic do_reset();
        calib = 1'b0;
        sys_rst = 1'b1;
        tick(3);
        sys_rst = 1'b0;
        tick(2);
    endtask

    initial begin
        tick(2);
        check("rst_app_en", app_en, 0);
        check("rst_wdf_wren", app_wdf_wren, 0);
        check("rst_wdf_end", app_wdf_end, 0);
        check("rst_cmd", app_cmd, 0);
        check("rst_addr", app_addr, 0);
        check("rst_wdf_data", app_wdf_data, 0);
        check("rst_err_flag", tg_compare_error, 0);
        check("rst_err_count", err_count, 0);
        check("rst_pass_count", pass_count, 0);
        sys_rst = 1'b0;
        l_rst = 1'b0;
        tick(3);
        check("idle_no_cmd_before_calib", app_en, 0);

        // Basic single pass, always ready.
        calib = 1'b1;
        for (int t = 0; t < 300 && pass_count != 1; t++) tick();
        check("basic_pass_count", pass_count, 1);
        check("basic_wr_cmds", wr_cmds, NB);
        check("basic_wr_beats", wr_beats, NB);
        check("basic_rd_beats", rd_beats, NB);
        check("basic_err_flag", tg_compare_error, 0);
        tick(10);
        junk_req = 1'b1;
        tick(3);
        junk_req = 1'b0;
        tick(3);
        check("done_ignores_rd_err_count", err_count, 0);
        check("done_ignores_rd_err_flag", tg_compare_error, 0);
        check("done_terminal_pass_count", pass_count, 1);
        check("done_terminal_app_en", app_en, 0);
        check("done_terminal_wr_cmds", wr_cmds, NB);

        // Command stalled on burst 2 while its data is accepted.
        do_reset();
        calib = 1'b1;
        for (int t = 0; t < 50 && wr_cmds < 2; t++) tick();
        rdy_val = 1'b0;
        check("stall_app_en", app_en, 1);
        check("stall_addr", app_addr, 16);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("stall_hold_app_en", app_en, 1);
            check("stall_hold_addr", app_addr, 16);
            check("stall_hold_wr_cmds", wr_cmds, 2);
        end
        check("stall_data_once", wr_beats, 3);
        check("stall_wren_dropped", app_wdf_wren, 0);
        rdy_val = 1'b1;
        for (int t = 0; t < 300 && pass_count != 1; t++) tick();
        check("stall_total_cmds", wr_cmds, NB);
        check("stall_total_beats", wr_beats, NB);
        check("stall_pass_count", pass_count, 1);

        // Corrupted read beat 1 under random backpressure and read latency.
        do_reset();
        corrupt_k = 1;
        rand_rdy = 1'b1;
        rd_slow = 1'b1;
        calib = 1'b1;
        for (int t = 0; t < 1500 && pass_count != 1; t++) tick();
        check("corrupt_pass_count", pass_count, 1);
        check("corrupt_err_count", err_count, 1);
        check("corrupt_err_flag", tg_compare_error, 1);
        check("corrupt_rd_beats", rd_beats, NB);
        corrupt_k = -1;
        rand_rdy = 1'b0;
        rd_slow = 1'b0;

        // Asynchronous reset on write burst 2.
        do_reset();
        calib = 1'b1;
        for (int t = 0; t < 50 && wr_cmds < 2; t++) tick();
        check("pre_rst_app_en", app_en, 1);
        sys_rst = 1'b1;
        #1;
        check("async_rst_app_en", app_en, 0);
        check("async_rst_wren", app_wdf_wren, 0);
        check("async_rst_wdf_end", app_wdf_end, 0);
        check("async_rst_addr", app_addr, 0);
        check("async_rst_data", app_wdf_data, 0);
        check("async_rst_cmd", app_cmd, 0);
        tick(2);
        sys_rst = 1'b0;
        for (int t = 0; t < 20 && wr_cmds < 1; t++) tick();
        check("restart_first_addr", first_addr, 0);
        for (int t = 0; t < 300 && pass_count != 1; t++) tick();
        check("restart_pass_count", pass_count, 1);
        check("restart_err_count", err_count, 0);

        // Calibration loss during READ after one error was logged.
        do_reset();
        corrupt_k = 0;
        calib = 1'b1;
        for (int t = 0; t < 100 && rd_beats < 2; t++) tick();
        calib = 1'b0;
        tick();
        check("calib_drop_app_en", app_en, 0);
        check("calib_drop_wren", app_wdf_wren, 0);
        check("calib_drop_err_count", err_count, 1);
        check("calib_drop_err_flag", tg_compare_error, 1);
        tick(4);
        check("calib_idle_app_en", app_en, 0);
        check("calib_idle_pass_count", pass_count, 0);
        corrupt_k = -1;
        calib = 1'b1;
        for (int t = 0; t < 300 && pass_count != 1; t++) tick();
        check("recal_first_addr", first_addr, 0);
        check("recal_wr_cmds", wr_cmds, NB);
        check("recal_pass_count", pass_count, 1);
        check("recal_err_count_kept", err_count, 1);

        // Looping generator: three passes with random backpressure.
        l_calib = 1'b1;
        for (int t = 0; t < 3000 && l_pass_count != 3; t++) tick();
        l_calib = 1'b0;
        check("loop_pass_count", l_pass_count, 3);
        check("loop_err_count", l_err_count, 0);
        check("loop_err_flag", l_tg, 0);
        for (int p = 0; p < 3; p++) check("loop_pass_byte", 128'(l_byte[p]), 128'(p));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
